// File: rtl/uart_pkg.sv
// Shared definitions for the UART transmit and receive paths.
// The PARITY state is always declared; it is only reachable when UART_TX_PARITY_EN is defined.
package uart_pkg;

    typedef enum logic [2:0] {
        ST_IDLE   = 3'd0,
        ST_START  = 3'd1,
        ST_DATA   = 3'd2,
        ST_PARITY = 3'd3,
        ST_STOP   = 3'd4
    } uart_state_t;

    localparam int   UART_DATA_BITS  = 8;
    localparam logic UART_IDLE_LEVEL = 1'b1;

endpackage

// File: rtl/uart_bit_timer.sv
// Per-bit cycle counter: runs 0..CYCLES_PER_BIT-1 and flags the last cycle of each bit.
// Shared with the receive path.
module uart_bit_timer #(
    parameter int CYCLES_PER_BIT = 10
) (
    input  logic clk,
    input  logic rst,
    input  logic clear,
    output logic bit_end
);

    localparam int CW = (CYCLES_PER_BIT > 1) ? $clog2(CYCLES_PER_BIT) : 1;
    localparam logic [CW-1:0] LAST = CW'(CYCLES_PER_BIT - 1);

    logic [CW-1:0] cyc;

    always_ff @(posedge clk or posedge rst) begin
        if (rst)
            cyc <= '0;
        else if (clear || bit_end)
            cyc <= '0;
        else
            cyc <= cyc + CW'(1);
    end

    assign bit_end = (cyc == LAST);

endmodule

// File: rtl/uart_tx.sv
// 8N1 UART transmitter with valid/ready byte input and registered txd.
// Define UART_TX_PARITY_EN to insert an even-parity bit between data and stop.
module uart_tx
    import uart_pkg::*;
#(
    parameter int CYCLES_PER_BIT = 10
) (
    input  logic       clk,
    input  logic       rst,
    input  logic [7:0] din,
    input  logic       din_valid,
    output logic       din_ready,
    output logic       txd,
    output logic       busy,
    output logic       done
);

    uart_state_t                state, state_nxt;
    logic [UART_DATA_BITS-1:0] sh, sh_nxt;
    logic [2:0]                 idx, idx_nxt;
    logic                       txd_nxt;
    logic                       bit_end;
    logic                       accept;
`ifdef UART_TX_PARITY_EN
    logic                       par, par_nxt;
`endif

    uart_bit_timer #(.CYCLES_PER_BIT(CYCLES_PER_BIT)) u_timer (
        .clk     (clk),
        .rst     (rst),
        .clear   (state == ST_IDLE),
        .bit_end (bit_end)
    );

    assign din_ready = (state == ST_IDLE) || ((state == ST_STOP) && bit_end);
    assign busy      = (state != ST_IDLE);
    assign done      = (state == ST_STOP) && bit_end;
    assign accept    = din_valid && din_ready;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= ST_IDLE;
            sh    <= '0;
            idx   <= '0;
            txd   <= UART_IDLE_LEVEL;
        end else begin
            state <= state_nxt;
            sh    <= sh_nxt;
            idx   <= idx_nxt;
            txd   <= txd_nxt;
        end
    end

`ifdef UART_TX_PARITY_EN
    always_ff @(posedge clk or posedge rst) begin
        if (rst)
            par <= 1'b0;
        else
            par <= par_nxt;
    end
`endif

    always_comb begin
        state_nxt = state;
        sh_nxt    = sh;
        idx_nxt   = idx;
`ifdef UART_TX_PARITY_EN
        par_nxt   = par;
`endif
        case (state)
            ST_IDLE: begin
                if (accept) begin
                    state_nxt = ST_START;
                    sh_nxt    = din;
`ifdef UART_TX_PARITY_EN
                    par_nxt   = ^din;
`endif
                end
            end
            ST_START: begin
                if (bit_end) begin
                    state_nxt = ST_DATA;
                    idx_nxt   = '0;
                end
            end
            ST_DATA: begin
                if (bit_end) begin
                    sh_nxt = {1'b0, sh[UART_DATA_BITS-1:1]};
                    if (idx == 3'(UART_DATA_BITS - 1))
`ifdef UART_TX_PARITY_EN
                        state_nxt = ST_PARITY;
`else
                        state_nxt = ST_STOP;
`endif
                    else
                        idx_nxt = idx + 3'd1;
                end
            end
`ifdef UART_TX_PARITY_EN
            ST_PARITY: begin
                if (bit_end)
                    state_nxt = ST_STOP;
            end
`endif
            ST_STOP: begin
                // an accept on the last stop cycle chains straight into the next start bit
                if (bit_end) begin
                    if (accept) begin
                        state_nxt = ST_START;
                        sh_nxt    = din;
`ifdef UART_TX_PARITY_EN
                        par_nxt   = ^din;
`endif
                    end else begin
                        state_nxt = ST_IDLE;
                    end
                end
            end
            default: state_nxt = ST_IDLE;
        endcase
    end

    // txd is registered from the next state so the line changes exactly on bit boundaries
    always_comb begin
        txd_nxt = UART_IDLE_LEVEL;
        case (state_nxt)
            ST_START:  txd_nxt = 1'b0;
            ST_DATA:   txd_nxt = sh_nxt[0];
`ifdef UART_TX_PARITY_EN
            ST_PARITY: txd_nxt = par_nxt;
`endif
            default:   txd_nxt = UART_IDLE_LEVEL;
        endcase
    end

endmodule

// File: tb/tb_uart_tx.sv
// Directed self-checking bench for uart_tx: CYCLES_PER_BIT=10 instance plus a CYCLES_PER_BIT=2 instance.
// Frame length follows UART_TX_PARITY_EN.
module tb_uart_tx;

    logic       clk = 1'b0;
    logic       rst;
    logic [7:0] din, din2;
    logic       din_valid, din_valid2;
    logic       din_ready, txd, busy, done;
    logic       din_ready2, txd2, busy2, done2;

    int total = 0;
    int bad   = 0;

`ifdef UART_TX_PARITY_EN
    localparam int NBITS = 11;
`else
    localparam int NBITS = 10;
`endif

    always #5 clk = ~clk;

    uart_tx #(.CYCLES_PER_BIT(10)) dut (
        .clk(clk), .rst(rst), .din(din), .din_valid(din_valid),
        .din_ready(din_ready), .txd(txd), .busy(busy), .done(done)
    );

    uart_tx #(.CYCLES_PER_BIT(2)) dut2 (
        .clk(clk), .rst(rst), .din(din2), .din_valid(din_valid2),
        .din_ready(din_ready2), .txd(txd2), .busy(busy2), .done(done2)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Called at cycle 0 of a frame (1 time unit after the accept edge); returns at the
    // cycle just after the frame. With jit set, din/din_valid are scrambled every cycle
    // and nxt is presented on the final stop cycle.
    task automatic frame(input bit sel, input logic [7:0] b, input bit jit,
                         input logic [7:0] nxt, input string tag);
        int   cpb;
        int   last;
        int   bi;
        logic e;
        cpb  = sel ? 2 : 10;
        last = NBITS * cpb - 1;
        for (int c = 0; c <= last; c++) begin
            bi = c / cpb;
            if (bi == 0)
                e = 1'b0;
            else if (bi <= 8)
                e = b[bi-1];
            else if (NBITS == 11 && bi == 9)
                e = ^b;
            else
                e = 1'b1;
            if (sel) begin
                chk($sformatf("%s c%0d txd", tag, c),   32'(txd2),       32'(e));
                chk($sformatf("%s c%0d busy", tag, c),  32'(busy2),      32'd1);
                chk($sformatf("%s c%0d done", tag, c),  32'(done2),      32'(c == last));
                chk($sformatf("%s c%0d ready", tag, c), 32'(din_ready2), 32'(c == last));
            end else begin
                chk($sformatf("%s c%0d txd", tag, c),   32'(txd),        32'(e));
                chk($sformatf("%s c%0d busy", tag, c),  32'(busy),       32'd1);
                chk($sformatf("%s c%0d done", tag, c),  32'(done),       32'(c == last));
                chk($sformatf("%s c%0d ready", tag, c), 32'(din_ready),  32'(c == last));
            end
            if (jit) begin
                din_valid = 1'b1;
                din       = (c == last) ? nxt : 8'(c * 37 + 1);
            end
            tick();
        end
    endtask

    task automatic chk_idle(input string tag);
        chk({tag, " txd"},   32'(txd),       32'd1);
        chk({tag, " busy"},  32'(busy),      32'd0);
        chk({tag, " ready"}, 32'(din_ready), 32'd1);
        chk({tag, " done"},  32'(done),      32'd0);
    endtask

    initial begin
        rst        = 1'b1;
        din        = 8'h00;
        din2       = 8'h00;
        din_valid  = 1'b0;
        din_valid2 = 1'b0;
        #1;
        chk_idle("reset");
        chk("reset txd2",  32'(txd2),       32'd1);
        chk("reset busy2", 32'(busy2),      32'd0);
        tick();
        tick();
        rst = 1'b0;
        tick();
        chk_idle("post-reset");

        // single byte 0x55
        din       = 8'h55;
        din_valid = 1'b1;
        tick();
        din_valid = 1'b0;
        din       = 8'hxx;
        frame(1'b0, 8'h55, 1'b0, 8'h00, "b55");
        chk_idle("after b55");

        // back-to-back 0xA3 then 0x0F with din_valid held
        tick();
        din       = 8'hA3;
        din_valid = 1'b1;
        tick();
        din = 8'h0F;
        frame(1'b0, 8'hA3, 1'b0, 8'h00, "bA3");
        din_valid = 1'b0;
        frame(1'b0, 8'h0F, 1'b0, 8'h00, "b0F");
        chk_idle("after b0F");

        // handshake hold: din scrambled while busy, only 0xC6 on the accept edge counts
        din       = 8'h3C;
        din_valid = 1'b1;
        tick();
        din_valid = 1'b0;
        frame(1'b0, 8'h3C, 1'b1, 8'hC6, "b3C");
        din_valid = 1'b0;
        din       = 8'h99;
        frame(1'b0, 8'hC6, 1'b0, 8'h00, "bC6");
        chk_idle("after bC6");

        // reset during data bit 3 of 0xFF
        din       = 8'hFF;
        din_valid = 1'b1;
        tick();
        din_valid = 1'b0;
        repeat (43) tick();
        chk("midframe busy", 32'(busy),      32'd1);
        chk("midframe ready", 32'(din_ready), 32'd0);
        rst = 1'b1;
        #1;
        chk_idle("async reset");
        tick();
        rst = 1'b0;
        for (int i = 0; i < 30; i++) begin
            chk($sformatf("post-abort c%0d txd", i),  32'(txd),  32'd1);
            chk($sformatf("post-abort c%0d busy", i), 32'(busy), 32'd0);
            tick();
        end

        // fresh frame after the abort
        din       = 8'h81;
        din_valid = 1'b1;
        tick();
        din_valid = 1'b0;
        frame(1'b0, 8'h81, 1'b0, 8'h00, "b81");
        chk_idle("after b81");

        // minimum rate, back-to-back 0x00 then 0xFF
        din2       = 8'h00;
        din_valid2 = 1'b1;
        tick();
        din2 = 8'hFF;
        frame(1'b1, 8'h00, 1'b0, 8'h00, "m00");
        din_valid2 = 1'b0;
        frame(1'b1, 8'hFF, 1'b0, 8'h00, "mFF");
        chk("min idle txd",   32'(txd2),       32'd1);
        chk("min idle busy",  32'(busy2),      32'd0);
        chk("min idle ready", 32'(din_ready2), 32'd1);

`ifdef UART_TX_PARITY_EN
        din       = 8'h07;
        din_valid = 1'b1;
        tick();
        din_valid = 1'b0;
        frame(1'b0, 8'h07, 1'b0, 8'h00, "p07");
        din       = 8'h03;
        din_valid = 1'b1;
        tick();
        din_valid = 1'b0;
        frame(1'b0, 8'h03, 1'b0, 8'h00, "p03");
        chk_idle("after p03");
`endif

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/uart_tx.md
# uart_tx

Serial transmitter for the project's UART link, the transmit counterpart of the existing receive path. It accepts a byte over a valid/ready handshake and shifts it out on a single line as an 8N1 frame: one start bit, 8 data bits LSB first, one stop bit. Downstream logic (command/response, debug print) feeds it bytes; its output drives the board TX pin.

## Interface
- `CYCLES_PER_BIT`, default 10: clock cycles per serial bit (100 MHz / 115200 in hardware builds); must be ≥ 2.
- `clk`  input  1  system clock; all state changes on the rising edge.
- `rst`  input  1  asynchronous, active-high reset.
- `din`  input  8  byte to send; sampled only on the accept edge.
- `din_valid`  input  1  `din` holds a byte to send.
- `din_ready`  output  1  transmitter can accept a byte this cycle.
- `txd`  output  1  serial line, idle high.
- `busy`  output  1  a frame is in progress (state ≠ IDLE).
- `done`  output  1  one-cycle pulse in the last cycle of the stop bit.

## Operation
- States: IDLE, START, DATA, STOP, plus PARITY when enabled.
- Bit counter `cyc` runs 0..CYCLES_PER_BIT-1 within each bit. Bit index `idx` runs 0..7 in DATA.
- Accept: occurs on the edge where `din_valid && din_ready`.
  - `din` is latched into shift register `sh`.
  - State goes to START and `cyc` is set to 0.
- `din_ready` is high in IDLE and in the final cycle of STOP (`cyc == CYCLES_PER_BIT-1`). It is low at all other times.
- START: `txd` = 0 for CYCLES_PER_BIT cycles, then DATA with `idx` = 0.
- DATA: `txd` = `sh[0]`. At the end of each bit, `sh` shifts right. After `idx` = 7 completes, the next state is STOP (or PARITY).
- STOP: `txd` = 1 for CYCLES_PER_BIT cycles.
  - On the final cycle, `done` = 1.
  - If an accept occurs on that same edge, the next state is START (back-to-back frames, no idle gap). Otherwise the next state is IDLE.
- Changes on `din` or `din_valid` outside the accept edge have no effect on the frame in flight.
- `txd` is driven from a register, so the line has no glitches.

## Timing
- Reset values, forced immediately while `rst` is high: `txd` = 1, `din_ready` = 1, `busy` = 0, `done` = 0, state IDLE, `cyc` = 0, `idx` = 0, `sh` = 0.
- Reset asserted mid-frame aborts the frame. The line returns high at once, and the aborted byte is not resent.
- Latency: if the accept happens at edge N, `txd` falls after edge N. Data bit k occupies edges N+(k+1)·CYCLES_PER_BIT through N+(k+2)·CYCLES_PER_BIT−1.
- Frame length is 10·CYCLES_PER_BIT cycles (11·CYCLES_PER_BIT with parity).
- Continuous `din_valid` gives one frame every 10·CYCLES_PER_BIT cycles with no extra idle cycles.
- `done` and a back-to-back accept can occur in the same cycle. Both are honoured.
- Widths: `cyc` is `$clog2(CYCLES_PER_BIT)` bits and `idx` is 3 bits. Neither counter wraps except through the explicit reset-to-0 at bit end.

## Configuration
- Macro: `UART_TX_PARITY_EN`.
- Defined:
  - A PARITY state is inserted between DATA and STOP.
  - `txd` = XOR of the 8 latched data bits (even parity) for CYCLES_PER_BIT cycles.
  - Parity is computed at accept time and held in a register.
  - Frame = 11 bits.
- Undefined: no parity state and no parity register; frame = 10 bits (8N1).

## Structure
- Shared package `uart_pkg`:
  - state enum (including PARITY, always declared);
  - `UART_DATA_BITS` = 8;
  - `UART_IDLE_LEVEL` = 1'b1.
- Sub-module `uart_bit_timer`:
  - wraps `cyc`;
  - inputs `clk`, `rst`, `clear`;
  - output `bit_end`, high when `cyc == CYCLES_PER_BIT-1`;
  - intended for reuse by the receive path.

## Test plan
- **Single byte:** `rst` pulse, then 0x55 with CYCLES_PER_BIT = 10 → `txd` low for 10 cycles, then 1,0,1,0,1,0,1,0 each for 10 cycles, then high for 10 cycles. `done` pulses at cycle 99 after accept. `busy` is high for exactly 100 cycles.
- **Back-to-back:** 0xA3 then 0x0F, with `din_valid` held → second start bit begins at cycle 100 with no idle gap. Decoded bits match LSB first. Total is 200 cycles; `din_ready` is high only at cycles 99 and 199.
- **Handshake hold:** `din_valid` raised while `busy`, with `din` changed every cycle → only the value present on the accept edge (cycle 99) is transmitted.
- **Reset mid-frame:** assert `rst` during data bit 3 of 0xFF → `txd` = 1, `busy` = 0, `din_ready` = 1 within the same cycle. After release, the line stays idle until a new accept.
- **Parity (`UART_TX_PARITY_EN` defined):** 0x07 → parity bit = 1; 0x03 → parity bit = 0. Frame = 110 cycles.
- **Minimum rate:** CYCLES_PER_BIT = 2, bytes 0x00 and 0xFF → bits last exactly 2 cycles each, frame = 20 cycles.
